// File: rtl/sync_debounce_edge_pkg.sv
// Shared types and constants for the debounce / edge-detect block.
package sync_debounce_edge_pkg;

  // Two stable states plus one "checking" state per direction.
  typedef enum logic [1:0] {
    STABLE_HI = 2'd0,
    CHK_LO    = 2'd1,
    STABLE_LO = 2'd2,
    CHK_HI    = 2'd3
  } state_t;

  // Width of the consecutive-sample counter used during a check.
  localparam int CNT_W = 8;

  // Stable state that corresponds to a given settled level.
  function automatic state_t stable_state(input logic lvl);
    return lvl ? STABLE_HI : STABLE_LO;
  endfunction

endpackage

// File: rtl/sync_debounce_edge_if.sv
// Signal bundle between the debounce block and its user.
// There is no valid/ready handshake here: data_i is a level that is sampled on
// every clock edge, level_o/rise_o/fall_o/glitch_cnt_o are valid on every cycle,
// and glitch_clr_i acts on the edge at which it is seen high.
interface sync_debounce_edge_if #(
  parameter int GLITCH_W = 8
);
  logic                data_i;
  logic                glitch_clr_i;
  logic                level_o;
  logic                rise_o;
  logic                fall_o;
  logic [GLITCH_W-1:0] glitch_cnt_o;

  modport master (
    output data_i, glitch_clr_i,
    input  level_o, rise_o, fall_o, glitch_cnt_o
  );

  modport slave (
    input  data_i, glitch_clr_i,
    output level_o, rise_o, fall_o, glitch_cnt_o
  );
endinterface

// File: rtl/sync_debounce_edge_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;

  // Count up on inc, hold at all-ones, clear (or reset) takes priority.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_value <= '0;
    end else if (inc && (r_value != {W{1'b1}})) begin
      r_value <= r_value + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign value = r_value;

endmodule

// File: rtl/sync_debounce_edge.sv
// Debouncer for an already-synchronized level: a new level is accepted only
// after STABLE_CNT consecutive equal samples; accepted transitions produce a
// one-cycle rise/fall pulse and aborted checks are counted as glitches.
module sync_debounce_edge
  import sync_debounce_edge_pkg::*;
#(
  parameter logic RST_VAL    = 1'b1,
  parameter int   STABLE_CNT = 4,
  parameter int   GLITCH_W   = 8
) (
  input  logic                 clki,
  input  logic                 rst,
  sync_debounce_edge_if.slave  bus,
  output state_t               dbg_state_o
);

  // Compare target is one bit wider than cnt so cnt+1 never wraps.
  localparam logic [CNT_W:0] LP_TARGET = STABLE_CNT[CNT_W:0];
  localparam bit             LP_ONE    = (STABLE_CNT == 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_level;
  logic               r_rise;
  logic               r_fall;

  logic               w_data;
  logic [CNT_W:0]     w_cnt_inc;
  logic               w_last;
  logic               w_glitch;
  logic [GLITCH_W-1:0] w_glitch_cnt;

  assign w_data    = bus.data_i;
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_inc == LP_TARGET);

  // A check that sees the old level again is abandoned and counted, even on
  // its final sample.
  assign w_glitch = ((r_state == CHK_LO) &&  w_data) ||
                    ((r_state == CHK_HI) && !w_data);

  // Debounce FSM; level and pulses are registered alongside the state.
  always_ff @(posedge clki) begin
    if (rst) begin
      r_state <= stable_state(RST_VAL);
      r_cnt   <= '0;
      r_level <= RST_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_HI: begin
          if (!w_data) begin
            if (LP_ONE) begin
              r_state <= STABLE_LO;
              r_level <= 1'b0;
              r_fall  <= 1'b1;
            end else begin
              r_state <= CHK_LO;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        CHK_LO: begin
          if (w_data) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
          end else if (w_last) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STABLE_LO: begin
          if (w_data) begin
            if (LP_ONE) begin
              r_state <= STABLE_HI;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
            end else begin
              r_state <= CHK_HI;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        CHK_HI: begin
          if (!w_data) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else if (w_last) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= stable_state(r_level);
          r_cnt   <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (GLITCH_W)
  ) u_glitch_cnt (
    .clk   (clki),
    .rst   (rst),
    .inc   (w_glitch),
    .clr   (bus.glitch_clr_i),
    .value (w_glitch_cnt)
  );

  assign bus.level_o      = r_level;
  assign bus.rise_o       = r_rise;
  assign bus.fall_o       = r_fall;
  assign bus.glitch_cnt_o = w_glitch_cnt;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: a STABLE_CNT=4 and a STABLE_CNT=1 instance
// share stimulus; a reference model feeds an expected-value queue per instance.
module tb_sync_debounce_edge;
  import sync_debounce_edge_pkg::*;

  localparam int OUT_W = 11; // {level, rise, fall, glitch[7:0]}

  typedef struct {
    logic       r;
    logic       d;
    logic       c;
    logic       lvl;
    logic       rise;
    logic       fall;
    logic [7:0] g;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg4;
  state_t dbg1;

  always #5 clk = ~clk;

  sync_debounce_edge_if #(.GLITCH_W(8)) bus4 ();
  sync_debounce_edge_if #(.GLITCH_W(8)) bus1 ();

  sync_debounce_edge #(.RST_VAL(1'b1), .STABLE_CNT(4), .GLITCH_W(8)) dut (
    .clki(clk), .rst(rst), .bus(bus4), .dbg_state_o(dbg4)
  );

  sync_debounce_edge #(.RST_VAL(1'b1), .STABLE_CNT(1), .GLITCH_W(8)) dut1 (
    .clki(clk), .rst(rst), .bus(bus1), .dbg_state_o(dbg1)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] exp_q1[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: run length of samples differing from the settled level.
  logic m_lvl[2];
  int   m_run[2];
  int   m_g[2];

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_push(input logic r, input logic d, input logic c);
    for (int k = 0; k < 2; k++) begin
      int   n;
      logic rise;
      logic fall;
      logic gl;
      n    = (k == 0) ? 4 : 1;
      rise = 1'b0;
      fall = 1'b0;
      gl   = 1'b0;
      if (r) begin
        m_lvl[k] = 1'b1;
        m_run[k] = 0;
        m_g[k]   = 0;
      end else begin
        if (d != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == n) begin
            rise     = d;
            fall     = ~d;
            m_lvl[k] = d;
            m_run[k] = 0;
          end
        end else begin
          if (m_run[k] > 0) gl = 1'b1;
          m_run[k] = 0;
        end
        if (c) m_g[k] = 0;
        else if (gl && m_g[k] < 255) m_g[k]++;
      end
      if (k == 0) exp_q.push_back({m_lvl[k], rise, fall, 8'(m_g[k])});
      else        exp_q1.push_back({m_lvl[k], rise, fall, 8'(m_g[k])});
    end
  endtask

  function automatic logic [OUT_W-1:0] act4();
    return {bus4.level_o, bus4.rise_o, bus4.fall_o, bus4.glitch_cnt_o};
  endfunction

  function automatic logic [OUT_W-1:0] act1();
    return {bus1.level_o, bus1.rise_o, bus1.fall_o, bus1.glitch_cnt_o};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic d, input logic c);
    logic [OUT_W-1:0] e;
    rst               = r;
    bus4.data_i       = d;
    bus4.glitch_clr_i = c;
    bus1.data_i       = d;
    bus1.glitch_clr_i = c;
    model_push(r, d, c);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_n4", 16'(act4()), 16'(e));
    e = exp_q1.pop_front();
    check("sb_n1", 16'(act1()), 16'(e));
  endtask

  task automatic add_vec(input int cnt, input logic r, input logic d, input logic c,
                         input logic lvl, input logic rise, input logic fall, input logic [7:0] g);
    vec_t v;
    v.r = r; v.d = d; v.c = c; v.lvl = lvl; v.rise = rise; v.fall = fall; v.g = g;
    for (int i = 0; i < cnt; i++) vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    m_lvl[0] = 1'b1; m_lvl[1] = 1'b1;
    m_run[0] = 0;    m_run[1] = 0;
    m_g[0]   = 0;    m_g[1]   = 0;
    bus4.data_i = 1'b1; bus4.glitch_clr_i = 1'b0;
    bus1.data_i = 1'b1; bus1.glitch_clr_i = 1'b0;

    // Row index = edge number; edges 0-1 in reset.
    add_vec(2, 1, 1, 0, 1, 0, 0, 8'd0);
    add_vec(8, 0, 1, 0, 1, 0, 0, 8'd0);  // edges 2..9: reset release, data high
    add_vec(3, 0, 0, 0, 1, 0, 0, 8'd0);  // edges 10..12: low check running
    add_vec(1, 0, 0, 0, 0, 0, 1, 8'd0);  // edge 13: accepted, fall pulse
    add_vec(2, 0, 0, 0, 0, 0, 0, 8'd0);  // edges 14..15: pulse gone
    add_vec(3, 0, 1, 0, 0, 0, 0, 8'd0);
    add_vec(1, 0, 1, 0, 1, 1, 0, 8'd0);  // edge 19: rise pulse
    add_vec(1, 0, 1, 0, 1, 0, 0, 8'd0);
    add_vec(3, 0, 0, 0, 1, 0, 0, 8'd0);  // three lows ...
    add_vec(2, 0, 1, 0, 1, 0, 0, 8'd1);  // ... return on last check cycle: glitch

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].d, vecs[i].c);
      check($sformatf("vec%0d", i), 16'(act4()),
            16'({vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].g}));
      if (i == 1) check("rst_state", 16'(dbg4), 16'(STABLE_HI));
    end

    // Saturation: 300 single-cycle low glitches on top of the one above.
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0);
      step(0, 1, 0);
    end
    check("glitch_sat", 16'(bus4.glitch_cnt_o), 16'd255);
    check("sat_level", 16'(bus4.level_o), 16'd1);
    step(0, 0, 0);
    step(0, 1, 1);  // clear concurrent with a glitch
    check("glitch_clr_wins", 16'(bus4.glitch_cnt_o), 16'd0);
    step(0, 0, 0);
    step(0, 1, 0);
    check("glitch_resume", 16'(bus4.glitch_cnt_o), 16'd1);

    // Reset pulsed in the middle of a low check.
    step(1, 1, 0);
    step(1, 1, 0);
    for (int i = 2; i < 10; i++) step(0, 1, 0);
    step(0, 0, 0);  // edge 10
    step(0, 0, 0);  // edge 11
    check("mid_chk_state", 16'(dbg4), 16'(CHK_LO));
    step(1, 0, 0);  // edge 12
    check("rst_mid_chk", 16'(act4()), 16'({1'b1, 1'b0, 1'b0, 8'd0}));
    check("rst_mid_state", 16'(dbg4), 16'(STABLE_HI));
    step(0, 1, 0);  // edge 13
    step(0, 0, 0);  // edge 14
    step(0, 0, 0);  // edge 15
    step(0, 0, 0);  // edge 16
    check("restart_e16", 16'(act4()), 16'({1'b1, 1'b0, 1'b0, 8'd0}));
    step(0, 0, 0);  // edge 17
    check("restart_e17", 16'(act4()), 16'({1'b0, 1'b0, 1'b1, 8'd0}));
    step(0, 0, 0);  // edge 18
    check("restart_e18", 16'(act4()), 16'({1'b0, 1'b0, 1'b0, 8'd0}));

    // Data already low on the first edge after reset release.
    step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    check("post_rst_hold", 16'(bus4.level_o), 16'd1);
    step(0, 0, 0);
    check("post_rst_fall", 16'(act4()), 16'({1'b0, 1'b0, 1'b1, 8'd0}));

    // STABLE_CNT=1 instance follows a toggling input with one-edge latency.
    step(1, 1, 0);
    step(1, 1, 0);
    check("n1_rst_state", 16'(dbg1), 16'(STABLE_HI));
    for (int i = 0; i < 20; i++) begin
      logic d;
      d = (i % 2) == 1;
      step(0, d, 0);
      check($sformatf("n1_toggle%0d", i), 16'(act1()), 16'({d, d, ~d, 8'd0}));
    end

    // Random runs of varying length with occasional clear and reset.
    for (int i = 0; i < 150; i++) begin
      logic d;
      int   len;
      d   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        step(1'($urandom_range(0, 49) == 0), d, 1'($urandom_range(0, 15) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
